// File: rtl/proc_run_ctrl_pkg.sv
// Shared definitions for the core run controller: FSM state codes and default
// parameter values used by the RTL and by anything that instantiates it.
package proc_run_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RESET = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned DEF_RESET_CYCLES = 3;
  localparam int unsigned DEF_MAX_CYCLES   = 7;
  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_AUTO_START   = 1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/proc_run_ctrl.sv
// Sequences a processor core through hold-in-reset, bounded run and stop,
// with start/abort handshake, halt detection, cycle counting and timeout.
module proc_run_ctrl
  import proc_run_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned AUTO_START   = DEF_AUTO_START
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             halt_in,
  output logic             core_rst_n,
  output logic             core_en,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam bit             LIMITED    = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(LIMITED ? (MAX_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RESET_CYCLES - 1);

  if ((RESET_CYCLES < 1) ||
      (64'(RESET_CYCLES) >= (64'd1 << CNT_W)) ||
      (64'(MAX_CYCLES) >= (64'd1 << CNT_W))) begin : g_bad_params
    $error("proc_run_ctrl: RESET_CYCLES must be 1..2^CNT_W-1 and MAX_CYCLES < 2^CNT_W");
  end

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] rst_cnt;
  logic             limit_hit;
  logic             cyc_clear;
  logic             cyc_en;
  logic             rst_clear;
  logic             core_rst_n_d;
  logic             core_en_d;
  logic             running_d;
  logic             done_d;
  logic             timeout_d;

  assign limit_hit = LIMITED && (cycle_count == LIMIT_LAST);

  // Next state plus the values every registered output takes with it
  always_comb begin
    state_d      = state_q;
    cyc_clear    = 1'b0;
    cyc_en       = 1'b0;
    rst_clear    = 1'b1;
    timeout_d    = timeout;
    case (state_q)
      ST_IDLE: begin
        if ((AUTO_START != 0) || start) state_d = ST_RESET;
      end
      ST_RESET: begin
        rst_clear = 1'b0;
        if (abort)                      state_d = ST_IDLE;
        else if (rst_cnt == RST_LAST)   state_d = ST_RUN;
      end
      ST_RUN: begin
        cyc_en = 1'b1;
        if (abort)                      state_d = ST_IDLE;
        else if (halt_in || limit_hit)  state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) state_d = ST_RESET;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_RESET) && (state_q != ST_RESET)) begin
      cyc_clear = 1'b1;
      timeout_d = 1'b0;
    end else if ((state_q == ST_RUN) && (state_d == ST_DONE)) begin
      timeout_d = !halt_in;
    end

    // Core stays out of reset in DONE so its state can be inspected
    core_rst_n_d = (state_d == ST_RUN) || (state_d == ST_DONE);
    core_en_d    = (state_d == ST_RUN);
    running_d    = (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rst_n <= 1'b0;
      core_en    <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      core_rst_n <= core_rst_n_d;
      core_en    <= core_en_d;
      running    <= running_d;
      done       <= done_d;
      timeout    <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_rst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (rst_clear),
    .en    (1'b1),
    .count (rst_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cyc_clear),
    .en    (cyc_en),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: default, manual-start and unlimited configurations
// checked against run-length/timeout expectations computed from the rules.
module tb_proc_run_ctrl;

  localparam int unsigned D_RC  = 3;
  localparam int unsigned D_MAX = 7;
  localparam int unsigned M_RC  = 5;
  localparam int unsigned M_MAX = 7;
  localparam int unsigned U_RC  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic r_start, r_abort, r_halt;
  logic sel_m;
  logic u_halt;

  logic d_start, d_abort, d_halt;
  logic m_start, m_abort, m_halt;
  logic d_core_rst_n, d_core_en, d_running, d_done, d_timeout;
  logic m_core_rst_n, m_core_en, m_running, m_done, m_timeout;
  logic u_core_rst_n, u_core_en, u_running, u_done, u_timeout;
  logic [15:0] d_cnt, m_cnt;
  logic [3:0]  u_cnt;
  logic [4:0]  o_vec;
  logic [15:0] o_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign d_start = sel_m ? 1'b0 : r_start;
  assign d_abort = sel_m ? 1'b0 : r_abort;
  assign d_halt  = sel_m ? 1'b0 : r_halt;
  assign m_start = sel_m ? r_start : 1'b0;
  assign m_abort = sel_m ? r_abort : 1'b0;
  assign m_halt  = sel_m ? r_halt  : 1'b0;

  // {running, core_en, core_rst_n, done, timeout} of the selected instance
  assign o_vec = sel_m ? {m_running, m_core_en, m_core_rst_n, m_done, m_timeout}
                       : {d_running, d_core_en, d_core_rst_n, d_done, d_timeout};
  assign o_cnt = sel_m ? m_cnt : d_cnt;

  proc_run_ctrl u_def (
    .clk(clk), .rst_n(rst_n), .start(d_start), .abort(d_abort), .halt_in(d_halt),
    .core_rst_n(d_core_rst_n), .core_en(d_core_en), .running(d_running),
    .done(d_done), .timeout(d_timeout), .cycle_count(d_cnt)
  );

  proc_run_ctrl #(.RESET_CYCLES(M_RC), .MAX_CYCLES(M_MAX), .CNT_W(16), .AUTO_START(0)) u_man (
    .clk(clk), .rst_n(rst_n), .start(m_start), .abort(m_abort), .halt_in(m_halt),
    .core_rst_n(m_core_rst_n), .core_en(m_core_en), .running(m_running),
    .done(m_done), .timeout(m_timeout), .cycle_count(m_cnt)
  );

  proc_run_ctrl #(.RESET_CYCLES(U_RC), .MAX_CYCLES(0), .CNT_W(4), .AUTO_START(1)) u_unl (
    .clk(clk), .rst_n(rst_n), .start(1'b0), .abort(1'b0), .halt_in(u_halt),
    .core_rst_n(u_core_rst_n), .core_en(u_core_en), .running(u_running),
    .done(u_done), .timeout(u_timeout), .cycle_count(u_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    r_start = 1'b0;
    r_abort = 1'b0;
    r_halt  = 1'b0;
    u_halt  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({d_running, d_core_en, d_core_rst_n, d_done, d_timeout} !== 5'b00000 || d_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_def: vec=%b cnt=%0d expected vec=00000 cnt=0",
               {d_running, d_core_en, d_core_rst_n, d_done, d_timeout}, d_cnt);
    end
    n_cmp++;
    if ({m_running, m_core_en, m_core_rst_n, m_done, m_timeout} !== 5'b00000 || m_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_man: vec=%b cnt=%0d expected vec=00000 cnt=0",
               {m_running, m_core_en, m_core_rst_n, m_done, m_timeout}, m_cnt);
    end
    n_cmp++;
    if ({u_running, u_core_en, u_core_rst_n, u_done, u_timeout} !== 5'b00000 || u_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL reset_unl: vec=%b cnt=%0d expected vec=00000 cnt=0",
               {u_running, u_core_en, u_core_rst_n, u_done, u_timeout}, u_cnt);
    end
  endtask

  // One full run on the selected instance; halt_at is the RUN cycle carrying
  // halt_in (0 or beyond the limit means the run ends by timeout)
  task automatic run_one(input bit by_reset, input int halt_at);
    int rc, mx, run_len;
    bit exp_to;
    rc      = sel_m ? int'(M_RC) : int'(D_RC);
    mx      = sel_m ? int'(M_MAX) : int'(D_MAX);
    exp_to  = !(halt_at >= 1 && halt_at <= mx);
    run_len = exp_to ? mx : halt_at;

    if (by_reset) begin
      apply_reset();
      rst_n = 1'b1;
      tick();
    end else begin
      r_start = 1'b1;
      tick();
      r_start = 1'b0;
    end
    n_cmp++;
    if (o_vec !== 5'b00000 || o_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL kick: vec=%b cnt=%0d expected vec=00000 cnt=0", o_vec, o_cnt);
    end
    for (int i = 2; i <= rc; i++) begin
      r_start = 1'($urandom_range(0, 1));
      tick();
      n_cmp++;
      if (o_vec !== 5'b00000) begin
        n_err++;
        $display("FAIL reset_hold: edge %0d vec=%b expected 00000", i, o_vec);
      end
    end
    r_start = 1'b0;
    tick();
    for (int k = 1; k <= run_len; k++) begin
      n_cmp++;
      if (o_vec !== 5'b11100 || o_cnt !== 16'(k - 1)) begin
        n_err++;
        $display("FAIL run: cycle %0d vec=%b cnt=%0d expected vec=11100 cnt=%0d",
                 k, o_vec, o_cnt, k - 1);
      end
      r_halt  = (k == halt_at);
      r_start = 1'($urandom_range(0, 1));
      tick();
    end
    r_halt  = 1'b0;
    r_start = 1'b0;
    n_cmp++;
    if (o_vec !== {4'b0011, exp_to} || o_cnt !== 16'(run_len)) begin
      n_err++;
      $display("FAIL done: halt_at=%0d vec=%b cnt=%0d expected vec=%b cnt=%0d",
               halt_at, o_vec, o_cnt, {4'b0011, exp_to}, run_len);
    end
    r_abort = 1'b1;
    tick();
    tick();
    r_abort = 1'b0;
    n_cmp++;
    if (o_vec !== {4'b0011, exp_to} || o_cnt !== 16'(run_len)) begin
      n_err++;
      $display("FAIL done_hold: vec=%b cnt=%0d expected vec=%b cnt=%0d",
               o_vec, o_cnt, {4'b0011, exp_to}, run_len);
    end
  endtask

  task automatic test_default();
    sel_m = 1'b0;
    run_one(1'b1, 0);
    run_one(1'b0, 4);
    run_one(1'b0, 7);
    repeat (5) run_one(1'b0, int'($urandom_range(0, 10)));
  endtask

  task automatic test_abort();
    sel_m = 1'b0;
    apply_reset();
    rst_n = 1'b1;
    repeat (int'(D_RC) + 1) tick();
    tick();
    r_abort = 1'b1;
    tick();
    r_abort = 1'b0;
    n_cmp++;
    if (o_vec !== 5'b00000 || o_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL abort_run: vec=%b cnt=%0d expected vec=00000 cnt=2", o_vec, o_cnt);
    end
    tick();
    n_cmp++;
    if (o_vec !== 5'b00000 || o_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL abort_restart: vec=%b cnt=%0d expected vec=00000 cnt=0", o_vec, o_cnt);
    end
    r_abort = 1'b1;
    tick();
    r_abort = 1'b0;
    for (int i = 0; i < int'(D_RC); i++) begin
      tick();
      n_cmp++;
      if (o_vec !== 5'b00000) begin
        n_err++;
        $display("FAIL abort_reset: edge %0d vec=%b expected 00000", i, o_vec);
      end
    end
    tick();
    n_cmp++;
    if (o_vec !== 5'b11100 || o_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL abort_rerun: vec=%b cnt=%0d expected vec=11100 cnt=0", o_vec, o_cnt);
    end
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_vec !== 5'b00000 || o_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL async_reset: vec=%b cnt=%0d expected vec=00000 cnt=0", o_vec, o_cnt);
    end
    tick();
  endtask

  task automatic test_manual();
    sel_m = 1'b1;
    apply_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (o_vec !== 5'b00000) begin
        n_err++;
        $display("FAIL idle_wait: cycle %0d vec=%b expected 00000", i, o_vec);
      end
    end
    run_one(1'b0, int'($urandom_range(1, 9)));
    run_one(1'b0, int'($urandom_range(0, 10)));
    run_one(1'b0, 0);
  endtask

  task automatic test_unlimited();
    logic [3:0] exp_cnt;
    apply_reset();
    rst_n = 1'b1;
    for (int i = 1; i <= int'(U_RC); i++) begin
      tick();
      n_cmp++;
      if (u_core_rst_n !== 1'b0) begin
        n_err++;
        $display("FAIL unl_reset: edge %0d core_rst_n=%b expected 0", i, u_core_rst_n);
      end
    end
    tick();
    for (int k = 1; k <= 20; k++) begin
      exp_cnt = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
      n_cmp++;
      if ({u_running, u_core_en, u_core_rst_n, u_done, u_timeout} !== 5'b11100 || u_cnt !== exp_cnt) begin
        n_err++;
        $display("FAIL unl_run: cycle %0d vec=%b cnt=%0d expected vec=11100 cnt=%0d",
                 k, {u_running, u_core_en, u_core_rst_n, u_done, u_timeout}, u_cnt, exp_cnt);
      end
      tick();
    end
    u_halt = 1'b1;
    tick();
    u_halt = 1'b0;
    n_cmp++;
    if ({u_running, u_core_en, u_core_rst_n, u_done, u_timeout} !== 5'b00110 || u_cnt !== 4'd15) begin
      n_err++;
      $display("FAIL unl_halt: vec=%b cnt=%0d expected vec=00110 cnt=15",
               {u_running, u_core_en, u_core_rst_n, u_done, u_timeout}, u_cnt);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    r_start = 1'b0;
    r_abort = 1'b0;
    r_halt  = 1'b0;
    u_halt  = 1'b0;
    sel_m   = 1'b0;
    test_reset();
    test_default();
    test_abort();
    test_manual();
    test_unlimited();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
